line_fault_monitor: RTL
=======================

Name: line_fault_monitor

Overview:
- Parametrised successor of the two-line carrier fault detector.
- Monitors NUM_LINES asynchronous line samples for activity (toggling) and qualifies the PHY link indication with a hold-off timer, a selectable fault policy (any/all), per-line masking, a post-fault backoff state and a saturating fault-event counter.
- Sits between the PHY/line receivers and the MAC link logic; link_ok gates the datapath.

Parameters:
- NUM_LINES, 2, number of monitored line samples (1..16).
- TMR_W, 9, width of per-line inactivity timer; FAULT_TIMEOUT must be < 2^TMR_W.
- FAULT_TIMEOUT, 128, cycles without a transition before a line is declared faulty.
- HOLD_W, 16, width of hold/backoff timer.
- LINK_UP_HOLD_OFF, 65535, cycles in HOLD before declaring link up.
- RECOVER_HOLD_OFF, 1024, fault-free cycles required in BACKOFF before returning to IDLE.
- FAULT_POLICY, 0, 0 = any unmasked line faulty, 1 = all unmasked lines faulty.
- CNT_W, 8, width of fault_cnt.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- link  in  1  raw PHY link indication, synchronous to clk.
- line_sample  in  NUM_LINES  asynchronous line samples.
- line_mask  in  NUM_LINES  1 = line monitored; quasi-static.
- clr_cnt  in  1  synchronous clear of fault_cnt.
- link_ok  out  1  qualified link status.
- line_fault  out  NUM_LINES  per-line fault flag.
- carrier_fault  out  1  policy-combined fault.
- fault_cnt  out  CNT_W  saturating count of UP/HOLD -> BACKOFF events.
- state  out  2  FSM state: IDLE=0, HOLD=1, UP=2, BACKOFF=3.

Behaviour:
- Reset: all registers clear asynchronously, including synchronisers and timers. link_ok=0, line_fault=0, carrier_fault=0, fault_cnt=0, state=IDLE.
- Per line:
  - 3-flop synchroniser s[0..2], ASYNC_REG.
  - edge = s[2]!=s[1].
  - Timer: edge -> 0, else increment, saturating at FAULT_TIMEOUT.
  - Masked line: timer held at 0, line_fault=0.
  - line_fault registered = mask & (timer==FAULT_TIMEOUT).
- carrier_fault, registered from line_fault:
  - policy 0: OR of line_fault.
  - policy 1: line_mask!=0 and every masked line faulty.
  - line_mask all zero -> carrier_fault=0.
- Latency: last toggle captured in s[0] at edge E -> timer=0 at E+2 -> line_fault at E+3+FAULT_TIMEOUT -> carrier_fault at E+4+FAULT_TIMEOUT -> link_ok low at E+5+FAULT_TIMEOUT.
- A single toggle clears line_fault 3 edges after capture and carrier_fault 1 edge later.
- FSM (registered state; link_ok and timers updated from next-state, same edge):
  - IDLE: hold_timer=0, link_ok=0. link && !carrier_fault -> HOLD.
  - HOLD: hold_timer increments each cycle from 0. Transition priority: !link -> IDLE, then carrier_fault -> BACKOFF, then hold_timer==LINK_UP_HOLD_OFF -> UP. UP is entered LINK_UP_HOLD_OFF+1 edges after HOLD entry.
  - UP: link_ok=1. !link -> IDLE (link_ok=0 same edge); else carrier_fault -> BACKOFF.
  - BACKOFF: link_ok=0, link ignored, hold_timer cleared on entry. Timer increments while !carrier_fault and restarts at 0 when carrier_fault=1. hold_timer==RECOVER_HOLD_OFF -> IDLE.
  - Simultaneous !link and carrier_fault in HOLD/UP -> IDLE; no count.
- fault_cnt:
  - +1 on each HOLD->BACKOFF or UP->BACKOFF transition; saturates at all-ones.
  - clr_cnt wins over a same-cycle increment.
- Width rules: hold_timer is HOLD_W bits; LINK_UP_HOLD_OFF and RECOVER_HOLD_OFF must be < 2^HOLD_W (elaboration-time assertion).
- Changing line_mask mid-operation takes effect on the next edge; no glitch protection beyond registering.

Decomposition:
- Package line_fault_pkg: state encoding constants (ST_IDLE, ST_HOLD, ST_UP, ST_BACKOFF), policy constants (POL_ANY=0, POL_ALL=1).
- Sub-module line_activity_timer (synchroniser, edge detect, saturating timer, mask, line_fault), instantiated NUM_LINES times via generate.
- Top contains the policy combine, FSM, hold timer and counter.

Test Plan (NUM_LINES=4, FAULT_TIMEOUT=16, LINK_UP_HOLD_OFF=32, RECOVER_HOLD_OFF=8, mask=4'hF):
- Bring-up: all lines toggle every 4 cycles, link 0->1 -> state HOLD 1 edge later, link_ok=1 exactly 33 edges after HOLD entry; fault_cnt=0.
- Single line stall, policy 0: in UP, stop line 2 -> line_fault=4'b0100 at E+19, link_ok=0 at E+21, state BACKOFF, fault_cnt=1. Resume toggling -> IDLE after 8 fault-free cycles, then HOLD/UP again.
- Policy 1: stall line 2 only -> link_ok stays 1; stall all four -> BACKOFF, fault_cnt=1. Mask line 3 with lines 0-2 stalled -> carrier_fault=1.
- Link drop: in HOLD at hold_timer=10, link->0 -> IDLE next edge, fault_cnt unchanged. Re-raise link -> hold_timer restarts at 0.
- Backoff restart and counter: fault recurs at backoff count 5 -> count restarts and IDLE is reached only after 8 clean cycles. Force 300 faults with CNT_W=8 -> fault_cnt=255; clr_cnt coincident with an increment -> 0.
- Reset mid-operation: assert rst in UP with line_fault active -> all outputs 0 and state IDLE immediately (asynchronous). After release, link_ok needs full HOLD again.

Source files
------------

// File: rtl/line_fault_pkg.sv
// Shared encodings for the line fault monitor: FSM states and fault-combine policies.
package line_fault_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HOLD    = 2'd1,
    ST_UP      = 2'd2,
    ST_BACKOFF = 2'd3
  } state_e;

  localparam int POL_ANY = 0;
  localparam int POL_ALL = 1;

endpackage

// File: rtl/line_activity_timer.sv
// One monitored line: 3-flop synchroniser, transition detect, saturating
// inactivity timer and the registered per-line fault flag.
module line_activity_timer #(
  parameter int TMR_W         = 9,
  parameter int FAULT_TIMEOUT = 128
) (
  input  logic clk,
  input  logic rst,
  input  logic sample,
  input  logic mask,
  output logic line_fault
);

  localparam logic [TMR_W-1:0] TMO = TMR_W'(FAULT_TIMEOUT);

  (* ASYNC_REG = "TRUE" *) logic [2:0] sync_q;
  logic [2:0]       sync_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             line_fault_q, line_fault_d;
  logic             edge_det;

  always_comb begin
    sync_d       = {sync_q[1:0], sample};
    edge_det     = sync_q[2] ^ sync_q[1];
    tmr_d        = tmr_q;
    // An unmonitored line is parked at zero so re-enabling it starts a fresh window.
    if (!mask || edge_det)  tmr_d = '0;
    else if (tmr_q != TMO)  tmr_d = tmr_q + 1'b1;
    line_fault_d = mask && (tmr_q == TMO);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q       <= '0;
      tmr_q        <= '0;
      line_fault_q <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      tmr_q        <= tmr_d;
      line_fault_q <= line_fault_d;
    end
  end

  assign line_fault = line_fault_q;

endmodule

// File: rtl/line_fault_monitor.sv
// Qualifies the PHY link with per-line activity faults: policy combine,
// IDLE/HOLD/UP/BACKOFF link FSM, hold/backoff timer and saturating fault counter.
module line_fault_monitor
  import line_fault_pkg::*;
#(
  parameter int NUM_LINES        = 2,
  parameter int TMR_W            = 9,
  parameter int FAULT_TIMEOUT    = 128,
  parameter int HOLD_W           = 16,
  parameter int LINK_UP_HOLD_OFF = 65535,
  parameter int RECOVER_HOLD_OFF = 1024,
  parameter int FAULT_POLICY     = 0,
  parameter int CNT_W            = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 link,
  input  logic [NUM_LINES-1:0] line_sample,
  input  logic [NUM_LINES-1:0] line_mask,
  input  logic                 clr_cnt,
  output logic                 link_ok,
  output logic [NUM_LINES-1:0] line_fault,
  output logic                 carrier_fault,
  output logic [CNT_W-1:0]     fault_cnt,
  output logic [1:0]           state
);

  if (NUM_LINES < 1 || NUM_LINES > 16) begin : g_chk_lines
    $error("line_fault_monitor: NUM_LINES must be 1..16");
  end
  if (FAULT_TIMEOUT >= (1 << TMR_W)) begin : g_chk_tmo
    $error("line_fault_monitor: FAULT_TIMEOUT does not fit TMR_W");
  end
  if (LINK_UP_HOLD_OFF >= (1 << HOLD_W) || RECOVER_HOLD_OFF >= (1 << HOLD_W)) begin : g_chk_hold
    $error("line_fault_monitor: hold-off constants do not fit HOLD_W");
  end

  localparam logic [HOLD_W-1:0] UP_HOLD  = HOLD_W'(LINK_UP_HOLD_OFF);
  localparam logic [HOLD_W-1:0] REC_HOLD = HOLD_W'(RECOVER_HOLD_OFF);

  for (genvar i = 0; i < NUM_LINES; i++) begin : g_line
    line_activity_timer #(
      .TMR_W        (TMR_W),
      .FAULT_TIMEOUT(FAULT_TIMEOUT)
    ) u_lat (
      .clk       (clk),
      .rst       (rst),
      .sample    (line_sample[i]),
      .mask      (line_mask[i]),
      .line_fault(line_fault[i])
    );
  end

  state_e              state_q, state_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [CNT_W-1:0]    fault_cnt_q, fault_cnt_d;
  logic                link_ok_q, link_ok_d;
  logic                carrier_fault_q, carrier_fault_d;
  logic [NUM_LINES-1:0] masked;
  logic                any_fault, all_fault, fault_evt;

  always_comb begin
    masked          = line_fault & line_mask;
    any_fault       = |masked;
    all_fault       = (line_mask != '0) && (masked == line_mask);
    carrier_fault_d = (FAULT_POLICY == POL_ANY) ? any_fault : all_fault;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (link && !carrier_fault_q) state_d = ST_HOLD;
      ST_HOLD: begin
        if (!link)                 state_d = ST_IDLE;
        else if (carrier_fault_q)  state_d = ST_BACKOFF;
        else if (hold_q == UP_HOLD) state_d = ST_UP;
      end
      ST_UP: begin
        if (!link)                 state_d = ST_IDLE;
        else if (carrier_fault_q)  state_d = ST_BACKOFF;
      end
      ST_BACKOFF: if (hold_q == REC_HOLD) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase

    // Timer restarts on every state entry; in BACKOFF only clean cycles count.
    hold_d = '0;
    if (state_q == ST_HOLD && state_d == ST_HOLD)
      hold_d = hold_q + 1'b1;
    else if (state_q == ST_BACKOFF && state_d == ST_BACKOFF && !carrier_fault_q)
      hold_d = hold_q + 1'b1;

    link_ok_d = (state_d == ST_UP);

    fault_evt   = (state_q == ST_HOLD || state_q == ST_UP) && (state_d == ST_BACKOFF);
    fault_cnt_d = fault_cnt_q;
    if (clr_cnt)                             fault_cnt_d = '0;
    else if (fault_evt && fault_cnt_q != '1) fault_cnt_d = fault_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      hold_q          <= '0;
      fault_cnt_q     <= '0;
      link_ok_q       <= 1'b0;
      carrier_fault_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      hold_q          <= hold_d;
      fault_cnt_q     <= fault_cnt_d;
      link_ok_q       <= link_ok_d;
      carrier_fault_q <= carrier_fault_d;
    end
  end

  assign link_ok       = link_ok_q;
  assign carrier_fault = carrier_fault_q;
  assign fault_cnt     = fault_cnt_q;
  assign state         = state_q;

endmodule
